// File: rtl/pll_lock_sequencer.sv
// Reset sequencer behind the system PLL: pulses the PLL reset, waits for a stable lock, then releases core reset.
// Optional build macro PLL_SEQ_TIMEOUT_EN re-pulses the PLL reset when lock is not seen within LOCK_TIMEOUT_CYCLES.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] relock_count
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lk_meta, lk_s;
    logic             relock_inc;

    // pll_locked is asynchronous to refclk; nothing else may look at it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        relock_inc = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = S_STABLE;
                end else begin
`ifdef PLL_SEQ_TIMEOUT_EN
                    if (cnt_q == TIMEOUT_LAST) state_d = S_PLL_RST;
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            S_STABLE: begin
                // Losing lock wins over the terminal count.
                if (!lk_s)                     state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!lk_s) begin
                    state_d    = S_WAIT_LOCK;
                    relock_inc = 1'b1;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            pll_rst      <= 1'b1;
            sys_reset    <= 1'b1;
            ready        <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst   <= (state_d == S_PLL_RST);
            sys_reset <= (state_d != S_RUN);
            ready     <= (state_d == S_RUN);
            if (relock_inc && (relock_count != 8'hFF)) relock_count <= relock_count + 8'd1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: expected state transitions (state, edge number) are queued as stimulus
// is driven and checked by a monitor as the DUT changes state. Honors PLL_SEQ_TIMEOUT_EN like the DUT.
module tb_pll_lock_sequencer;

    localparam int W = 34;  // {edge number[31:0], state[1:0]}

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_reset, ready;
    logic [1:0] state;
    logic [7:0] relock_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [1:0]   prev_state = 2'd0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_W              (20)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .state       (state),
        .relock_count(relock_count)
    );

    // 50 MHz reference clock, edge counter
    always #10 refclk = ~refclk;
    always @(posedge refclk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sb_push(input logic [1:0] st, input int at_edge);
        exp_q.push_back({at_edge[31:0], st});
    endtask

    // Returns #1 after the rising edge numbered c.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic do_reset(input logic lock_val, output int rel_edge);
        rst        = 1'b1;
        pll_locked = lock_val;
        @(posedge refclk);
        @(posedge refclk);
        #1;
        rst      = 1'b0;
        rel_edge = cyc;
    endtask

    // Monitor: every state change must match the head of the expected queue.
    always @(negedge refclk) begin
        if (rst) begin
            prev_state = 2'd0;
        end else if (state != prev_state) begin
            check("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("tr_state", 32'(state), 32'(mon_e[1:0]));
                check("tr_edge", cyc, mon_e[33:2]);
                check("tr_pll_rst", 32'(pll_rst), 32'(mon_e[1:0] == 2'd0));
                check("tr_sys_reset", 32'(sys_reset), 32'(mon_e[1:0] != 2'd3));
                check("tr_ready", 32'(ready), 32'(mon_e[1:0] == 2'd3));
            end
            prev_state = state;
        end
    end

    initial begin
        int r, s, d;

        // Reset values
        repeat (3) @(posedge refclk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_pll_rst", 32'(pll_rst), 1);
        check("rst_sys_reset", 32'(sys_reset), 1);
        check("rst_ready", 32'(ready), 0);
        check("rst_relock", 32'(relock_count), 0);

        // Clean start with lock already high
        do_reset(1'b1, r);
        sb_push(2'd1, r + 4);
        sb_push(2'd2, r + 5);
        sb_push(2'd3, r + 13);
        wait_until(r + 14);
        check("clean_state", 32'(state), 3);
        check("clean_ready", 32'(ready), 1);
        check("clean_relock", 32'(relock_count), 0);

        // Unstable lock during STABLE, then lock drop landing on the terminal count
        do_reset(1'b0, r);
        sb_push(2'd1, r + 4);
        wait_until(r + 6);
        pll_locked = 1'b1;
        s = r + 9;
        sb_push(2'd2, s);
        wait_until(s + 4);
        pll_locked = 1'b0;
        sb_push(2'd1, s + 7);
        wait_until(s + 7);
        pll_locked = 1'b1;
        sb_push(2'd2, s + 10);
        sb_push(2'd3, s + 18);
        wait_until(s + 20);
        check("unstable_state", 32'(state), 3);
        d = cyc;
        pll_locked = 1'b0;
        sb_push(2'd1, d + 3);
        wait_until(d + 10);
        pll_locked = 1'b1;
        sb_push(2'd2, d + 13);
        wait_until(d + 18);
        pll_locked = 1'b0;
        sb_push(2'd1, d + 21);
        wait_until(d + 21);
        pll_locked = 1'b1;
        sb_push(2'd2, d + 24);
        sb_push(2'd3, d + 32);
        wait_until(d + 33);
        check("simul_state", 32'(state), 3);
        check("simul_relock", 32'(relock_count), 1);

        // Lock never arrives
        do_reset(1'b0, r);
        sb_push(2'd1, r + 4);
`ifdef PLL_SEQ_TIMEOUT_EN
        sb_push(2'd0, r + 36);
        sb_push(2'd1, r + 40);
        sb_push(2'd0, r + 72);
        sb_push(2'd1, r + 76);
`endif
        wait_until(r + 74);
`ifdef PLL_SEQ_TIMEOUT_EN
        check("timeout_pll_rst", 32'(pll_rst), 1);
`else
        check("timeout_pll_rst", 32'(pll_rst), 0);
`endif
        wait_until(r + 80);
        check("timeout_sys_reset", 32'(sys_reset), 1);
        check("timeout_state", 32'(state), 1);

        // Repeated lock loss in RUN: relock_count saturates, no PLL reset pulses
        do_reset(1'b1, r);
        sb_push(2'd1, r + 4);
        sb_push(2'd2, r + 5);
        sb_push(2'd3, r + 13);
        wait_until(r + 14);
        for (int i = 0; i < 300; i++) begin
            d = cyc;
            pll_locked = 1'b0;
            sb_push(2'd1, d + 3);
            wait_until(d + 10);
            pll_locked = 1'b1;
            sb_push(2'd2, d + 13);
            sb_push(2'd3, d + 21);
            wait_until(d + 23);
            if (i == 99) check("relock_100", 32'(relock_count), 100);
        end
        check("relock_sat", 32'(relock_count), 255);

        // Async reset in the middle of STABLE
        d = cyc;
        pll_locked = 1'b0;
        sb_push(2'd1, d + 3);
        wait_until(d + 10);
        pll_locked = 1'b1;
        sb_push(2'd2, d + 13);
        wait_until(d + 16);
        check("relock_sat2", 32'(relock_count), 255);
        check("mid_stable", 32'(state), 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_state", 32'(state), 0);
        check("async_pll_rst", 32'(pll_rst), 1);
        check("async_sys_reset", 32'(sys_reset), 1);
        check("async_ready", 32'(ready), 0);
        check("async_relock", 32'(relock_count), 0);

        repeat (3) @(posedge refclk);
        #1;
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
